// File: rtl/controlador_pkg.sv
// controlador_pkg: digit width, digit type and transmit FSM states shared with the code-lock controller.
package controlador_pkg;
   localparam int DIGIT_W = 4;
   typedef logic [DIGIT_W-1:0] digit_t;
   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} estado_t;
endpackage

// File: rtl/entrada_digitos_if.sv
// entrada_digitos_if: board-side inputs and controller-side digit stream of the keypad front-end.
interface entrada_digitos_if #(parameter int FIFO_DEPTH = 8);
   import controlador_pkg::*;
   logic botao;
   digit_t chaves;
   logic limpa;
   digit_t numero;
   logic insere;
   logic [$clog2(FIFO_DEPTH):0] pendentes;
   logic erro_digito;
   logic estouro;
   modport master(input botao, chaves, limpa, output numero, insere, pendentes, erro_digito, estouro);
   modport slave(output botao, chaves, limpa, input numero, insere, pendentes, erro_digito, estouro);
endinterface

// File: rtl/debounce_botao.sv
// debounce_botao: synchronizes the raw button, filters bounces and pulses pressao on an accepted 0->1 edge.
module debounce_botao #(parameter int DEBOUNCE_CYCLES = 16) (
   input  logic clk,
   input  logic reset,
   input  logic botao,
   output logic pressao
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0] sinc;
   logic anterior, nivel, pronto;
   logic [CW-1:0] cnt;
   assign pronto = cnt == CW'(DEBOUNCE_CYCLES);
   assign pressao = pronto && anterior && !nivel;
   always_ff @(posedge clk)
      if (reset) begin
         sinc <= '0;
         anterior <= 1'b0;
         nivel <= 1'b0;
         cnt <= '0;
      end else begin
         sinc <= {sinc[0], botao};
         anterior <= sinc[1];
         cnt <= (sinc[1] != anterior) ? '0 : pronto ? cnt : cnt + CW'(1);
         if (pronto) nivel <= anterior;
      end
endmodule

// File: rtl/entrada_digitos.sv
// entrada_digitos: debounces keypad presses, queues legal digits and strobes them out one at a time.
module entrada_digitos
   import controlador_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int GAP_CYCLES = 2,
   parameter int DIGIT_MAX = 9
) (
   input logic clk,
   input logic reset,
   entrada_digitos_if.master io
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
   digit_t sinc_c, chave;
   digit_t mem [FIFO_DEPTH];
   logic [AW-1:0] wr, rd;
   logic [GW-1:0] gcnt;
   estado_t estado;
   logic pressao, aceita, valido, cheio, pop, push;
   debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk(clk), .reset(reset), .botao(io.botao), .pressao(pressao)
   );
   // a press in a flush cycle is dropped, but the debouncer still tracks it
   assign aceita = pressao && !io.limpa;
   assign valido = chave <= digit_t'(DIGIT_MAX);
   assign cheio = io.pendentes == CW'(FIFO_DEPTH);
   assign pop = estado == IDLE && io.pendentes != '0 && !io.limpa;
   assign push = aceita && valido && (!cheio || pop);
   always_ff @(posedge clk)
      if (reset) begin
         sinc_c <= '0;
         chave <= '0;
         wr <= '0;
         rd <= '0;
         gcnt <= '0;
         estado <= IDLE;
         io.numero <= '0;
         io.insere <= 1'b0;
         io.pendentes <= '0;
         io.erro_digito <= 1'b0;
         io.estouro <= 1'b0;
      end else begin
         sinc_c <= io.chaves;
         chave <= sinc_c;
         io.erro_digito <= aceita && !valido;
         io.estouro <= aceita && valido && cheio && !pop;
         if (push) mem[wr] <= chave;
         if (io.limpa) begin
            wr <= '0;
            rd <= '0;
            estado <= IDLE;
            io.insere <= 1'b0;
            io.pendentes <= '0;
         end else begin
            if (push) wr <= wr + AW'(1);
            if (pop) rd <= rd + AW'(1);
            if (pop) io.numero <= mem[rd];
            io.insere <= pop;
            io.pendentes <= io.pendentes + CW'(push) - CW'(pop);
            // the pop cycle moves to SEND, so the registered strobe coincides with SEND
            estado <= pop ? SEND : (estado == SEND) ? (GAP_CYCLES == 0 ? IDLE : GAP) :
                      (estado == GAP && gcnt == '0) ? IDLE : estado;
            gcnt <= (estado == SEND) ? GW'(GAP_CYCLES - 1) : gcnt - GW'(gcnt != '0);
         end
      end
endmodule

// File: tb/tb_entrada_digitos.sv
// tb_entrada_digitos: table-driven, directed and random checks of the keypad front-end against a digit-list model.
module tb_entrada_digitos;
   import controlador_pkg::*;
   localparam int DC = 16, FD = 8, GC = 2;
   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;
   entrada_digitos_if #(.FIFO_DEPTH(FD)) io();
   entrada_digitos #(.DEBOUNCE_CYCLES(DC), .FIFO_DEPTH(FD), .GAP_CYCLES(GC), .DIGIT_MAX(9)) dut (
      .clk(clk), .reset(reset), .io(io)
   );
   typedef struct {int dig; int ins; int err;} vetor_t;
   vetor_t tabela [6];
   int n_chk = 0, n_ok = 0;
   int cyc = 0, n_err = 0, n_est = 0;
   int strobes[$], t_ins[$];
   always @(negedge clk) begin
      cyc++;
      if (io.insere) begin
         strobes.push_back(int'(io.numero));
         t_ins.push_back(cyc);
      end
      if (io.erro_digito) n_err++;
      if (io.estouro) n_est++;
   end
   task automatic check(input string nome, input int got, input int exp);
      n_chk++;
      if (got == exp) n_ok++;
      else $display("FAIL %s: got %0d expected %0d", nome, got, exp);
   endtask
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask
   task automatic press(input int dig, input int hold, input int rel);
      io.chaves = digit_t'(dig);
      tick(3);
      io.botao = 1'b1;
      tick(hold);
      io.botao = 1'b0;
      tick(rel);
   endtask
   task automatic wait_strobe(input string nome);
      for (int i = 0; i < 60 && !io.insere; i++) tick(1);
      check(nome, int'(io.insere), 1);
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int b, be, last, exp_q[$], exp_err;
      io.botao = 1'b0;
      io.chaves = '0;
      io.limpa = 1'b0;
      tabela[0] = '{0, 1, 0};
      tabela[1] = '{9, 1, 0};
      tabela[2] = '{10, 0, 1};
      tabela[3] = '{12, 0, 1};
      tabela[4] = '{15, 0, 1};
      tabela[5] = '{5, 1, 0};
      tick(5);
      reset = 1'b0;
      check("reset_numero", int'(io.numero), 0);
      check("reset_insere", int'(io.insere), 0);
      check("reset_pendentes", int'(io.pendentes), 0);
      check("reset_erro", int'(io.erro_digito), 0);
      check("reset_estouro", int'(io.estouro), 0);
      tick(5);
      b = strobes.size();
      press(7, 20, 30);
      check("press7_count", strobes.size() - b, 1);
      check("press7_numero", strobes.size() > b ? strobes[b] : -1, 7);
      check("press7_held", int'(io.numero), 7);
      check("press7_pendentes", int'(io.pendentes), 0);
      b = strobes.size();
      io.chaves = 4'd3;
      for (int i = 0; i < 8; i++) begin
         io.botao = ~io.botao;
         tick(5);
      end
      io.botao = 1'b1;
      tick(30);
      io.botao = 1'b0;
      tick(30);
      check("glitch_count", strobes.size() - b, 1);
      check("glitch_numero", int'(io.numero), 3);
      last = 3;
      foreach (tabela[k]) begin
         b = strobes.size();
         be = n_err;
         press(tabela[k].dig, 25, 30);
         last = tabela[k].ins != 0 ? tabela[k].dig : last;
         check($sformatf("vec%0d_insere", k), strobes.size() - b, tabela[k].ins);
         check($sformatf("vec%0d_erro", k), n_err - be, tabela[k].err);
         check($sformatf("vec%0d_numero", k), int'(io.numero), last);
         check($sformatf("vec%0d_pendentes", k), int'(io.pendentes), 0);
      end
      b = strobes.size();
      be = n_est;
      force dut.estado = GAP;
      for (int d = 1; d <= 8; d++) press(d, 22, 28);
      check("fill_pendentes", int'(io.pendentes), 8);
      check("fill_estouro", n_est - be, 0);
      press(9, 22, 28);
      check("over_estouro", n_est - be, 1);
      check("over_pendentes", int'(io.pendentes), 8);
      check("over_no_insere", strobes.size() - b, 0);
      release dut.estado;
      tick(60);
      check("drain_count", strobes.size() - b, 8);
      check("drain_pendentes", int'(io.pendentes), 0);
      for (int i = 0; i < 8 && b + i < strobes.size(); i++)
         check($sformatf("drain_digit%0d", i), strobes[b + i], i + 1);
      for (int i = 1; i < 8 && b + i < t_ins.size(); i++)
         check($sformatf("drain_gap%0d", i), t_ins[b + i] - t_ins[b + i - 1], GC + 2);
      force dut.estado = GAP;
      for (int d = 4; d <= 6; d++) press(d, 22, 28);
      b = strobes.size();
      release dut.estado;
      wait_strobe("limpa_first_strobe");
      tick(1);
      io.limpa = 1'b1;
      tick(1);
      io.limpa = 1'b0;
      check("limpa_pendentes", int'(io.pendentes), 0);
      check("limpa_insere", int'(io.insere), 0);
      tick(20);
      check("limpa_count", strobes.size() - b, 1);
      check("limpa_numero", int'(io.numero), 4);
      force dut.estado = GAP;
      press(2, 22, 28);
      press(8, 22, 28);
      b = strobes.size();
      release dut.estado;
      wait_strobe("rst_first_strobe");
      reset = 1'b1;
      tick(1);
      check("rst_insere", int'(io.insere), 0);
      tick(1);
      reset = 1'b0;
      tick(20);
      check("rst_count", strobes.size() - b, 1);
      check("rst_pendentes", int'(io.pendentes), 0);
      b = strobes.size();
      be = n_err;
      exp_err = 0;
      for (int i = 0; i < 12; i++) begin
         int dig = int'($urandom_range(0, 15));
         for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
            io.botao = 1'b1;
            tick(int'($urandom_range(1, 6)));
            io.botao = 1'b0;
            tick(int'($urandom_range(1, 6)));
         end
         press(dig, int'($urandom_range(20, 30)), int'($urandom_range(26, 35)));
         if (dig <= 9) exp_q.push_back(dig);
         else exp_err++;
      end
      tick(10);
      check("rand_count", strobes.size() - b, exp_q.size());
      check("rand_erro", n_err - be, exp_err);
      foreach (exp_q[i])
         check($sformatf("rand_digit%0d", i), b + i < strobes.size() ? strobes[b + i] : -1, exp_q[i]);
      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end
endmodule
